// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Purpose  : Main control FSM for the multicycle MIPS datapath. Sequences
//            fetch, decode, execute, memory access and write-back. It drives
//            the datapath mux selects, the write enables and the 2-bit ALU
//            opcode. It also stalls on a single-ready memory handshake and
//            flags unsupported opcodes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   opcode[5:0] in   IR[31:26], valid from DECODE onward
//   zero        in   ALU zero flag (used combinationally in BRANCH)
//   mem_ready   in   memory completes the current access this cycle
//   PCWrite     out  PC load enable (branch condition folded in)
//   IorD        out  memory address select: 0 = PC, 1 = ALUOut
//   MemRead     out  memory read strobe
//   MemWrite    out  memory write strobe
//   IRWrite     out  instruction register load
//   RegDst      out  write-register select: 0 = rt, 1 = rd
//   MemtoReg    out  write-back source: 0 = ALUOut, 1 = MDR
//   RegWrite    out  register file write
//   ALUSrcA     out  ALU A select: 0 = PC, 1 = reg A
//   ALUSrcB     out  ALU B select: 00 B, 01 four, 10 imm, 11 imm<<2
//   ALUOpcode   out  00 add, 01 subtract, 10 use funct
//   PCSource    out  00 ALU result, 01 ALUOut, 10 jump target
//   instr_done  out  one-cycle pulse in the last cycle of an instruction
//   illegal_op  out  one-cycle pulse on an unsupported opcode
//   state[3:0]  out  current state, for debug
// ============================================================================
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOpcode,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    // Pure state-decoded (Moore) control word.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic ctrl_t moore_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                c.alu_src_b = 2'b11;
                c.alu_op    = 2'b00;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b10;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b01;
                c.pc_source = 2'b01;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
            end
            S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b00;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state_q,  state_d;
    logic [5:0] op_q,     op_d;
    ctrl_t      ctrl_q,   ctrl_d;
    ctrl_t      w_ctrl;

    // Handshake- and flag-dependent outputs, valid for the current state.
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_done;
    logic       w_illegal;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        w_pc_write = 1'b0;
        w_ir_write = 1'b0;
        w_done     = 1'b0;
        w_illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // IR load and PC+4 both commit only when the fetch completes.
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    C_OP_LW,
                    C_OP_SW:    state_d = S_MEM_ADDR;
                    C_OP_RTYPE: state_d = S_R_EXEC;
                    C_OP_BEQ,
                    C_OP_BNE:   state_d = S_BRANCH;
                    C_OP_J:     state_d = S_JUMP;
                    C_OP_ADDI:  state_d = S_ADDI_EXEC;
                    default: begin
                        w_illegal = 1'b1;
                        w_done    = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                state_d = (op_q == C_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                w_done  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    w_done  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                state_d = S_R_WB;
            end
            S_R_WB: begin
                w_done  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                // zero comes from the subtract performed in this same cycle.
                w_pc_write = ((op_q == C_OP_BEQ) &  zero) |
                             ((op_q == C_OP_BNE) & ~zero);
                w_done     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                w_done     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_done  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Control word is decoded from the next state so that it is
        // registered and lines up with state_q after the edge.
        ctrl_d = moore_decode(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            ctrl_q  <= moore_decode(S_FETCH);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // The registered control word already holds FETCH values during reset so
    // that the first cycle after release fetches. It is masked while rst is
    // high so that nothing is strobed during reset.
    assign w_ctrl     = rst ? '0 : ctrl_q;

    assign IorD       = w_ctrl.iord;
    assign MemRead    = w_ctrl.mem_read;
    assign MemWrite   = w_ctrl.mem_write;
    assign RegDst     = w_ctrl.reg_dst;
    assign MemtoReg   = w_ctrl.mem_to_reg;
    assign RegWrite   = w_ctrl.reg_write;
    assign ALUSrcA    = w_ctrl.alu_src_a;
    assign ALUSrcB    = w_ctrl.alu_src_b;
    assign ALUOpcode  = w_ctrl.alu_op;
    assign PCSource   = w_ctrl.pc_source;

    assign PCWrite    = ~rst & w_pc_write;
    assign IRWrite    = ~rst & w_ir_write;
    assign instr_done = ~rst & w_done;
    assign illegal_op = ~rst & w_illegal;

    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_control
// Purpose  : Scoreboard bench for mips_multicycle_control. A generator
//            expands each randomized instruction into a per-cycle input
//            script. It also computes the expected per-instruction summary:
//            state path, latency and strobe counts. A monitor accumulates the
//            DUT outputs per instruction and compares them on instr_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst;
    logic       MemtoReg, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, ALUOpcode, PCSource;
    logic [3:0] state;

    mips_multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOpcode  (ALUOpcode),
        .PCSource   (PCSource),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    logic [17:0] w_all_outs;
    assign w_all_outs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst,
                         MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOpcode,
                         PCSource, instr_done, illegal_op};

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected per-instruction summary.
    typedef struct {
        int          lat;
        logic [63:0] sig;      // state path, one nibble per cycle
        int          n_rw;     // RegWrite cycles
        int          n_mwacc;  // MemWrite cycles with mem_ready
        int          n_pcw;    // PCWrite cycles
        int          n_irw;    // IRWrite cycles
        int          n_ill;    // illegal_op cycles
        int          n_iord;   // IorD cycles
        int          n_mr;     // MemRead cycles
        logic        wb_mtr;   // MemtoReg seen with RegWrite
        logic        wb_rd;    // RegDst seen with RegWrite
        logic [3:0]  alu_mask; // one-hot set of ALUOpcode values seen
        logic [1:0]  pcsrc;    // PCSource on a non-fetch PC write, 3 = none
    } exp_t;

    typedef struct packed {
        logic       mr;
        logic       z;
        logic [5:0] op;
    } cyc_t;

    exp_t exp_q[$];
    cyc_t cyc_q[$];
    exp_t e_build;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    task automatic add(input int st, input logic mr, input logic z,
                       input logic [5:0] op);
        cyc_t c;
        c.mr = mr;
        c.z  = z;
        c.op = op;
        cyc_q.push_back(c);
        e_build.sig = (e_build.sig << 4) | 64'(st);
        e_build.lat++;
    endtask

    // Build the expected path from the instruction-level sequencing rules,
    // push the expectation, then play out the cycle script.
    task automatic issue(input logic [5:0] op, input logic z, input int fs,
                         input int ms);
        cyc_q.delete();
        e_build          = '{default: 0};
        e_build.alu_mask = 4'b0001;
        e_build.pcsrc    = 2'd3;
        e_build.n_pcw    = 1;
        e_build.n_irw    = 1;
        e_build.n_mr     = fs + 1;

        for (int i = 0; i < fs; i++) add(0, 1'b0, 1'($urandom), 6'($urandom));
        add(0, 1'b1, 1'($urandom), 6'($urandom));
        add(1, 1'($urandom), 1'($urandom), op);

        case (op)
            OP_R: begin
                add(6, 1'($urandom), 1'($urandom), 6'($urandom));
                add(7, 1'($urandom), 1'($urandom), 6'($urandom));
                e_build.n_rw = 1;
                e_build.wb_rd = 1'b1;
                e_build.alu_mask |= 4'b0100;
            end
            OP_LW: begin
                add(2, 1'($urandom), 1'($urandom), 6'($urandom));
                for (int i = 0; i < ms; i++) add(3, 1'b0, 1'($urandom), 6'($urandom));
                add(3, 1'b1, 1'($urandom), 6'($urandom));
                add(4, 1'($urandom), 1'($urandom), 6'($urandom));
                e_build.n_rw   = 1;
                e_build.wb_mtr = 1'b1;
                e_build.n_iord = ms + 1;
                e_build.n_mr  += ms + 1;
            end
            OP_SW: begin
                add(2, 1'($urandom), 1'($urandom), 6'($urandom));
                for (int i = 0; i < ms; i++) add(5, 1'b0, 1'($urandom), 6'($urandom));
                add(5, 1'b1, 1'($urandom), 6'($urandom));
                e_build.n_mwacc = 1;
                e_build.n_iord  = ms + 1;
            end
            OP_BEQ, OP_BNE: begin
                add(8, 1'($urandom), z, 6'($urandom));
                e_build.alu_mask |= 4'b0010;
                if ((op == OP_BEQ && z) || (op == OP_BNE && !z)) begin
                    e_build.n_pcw++;
                    e_build.pcsrc = 2'd1;
                end
            end
            OP_J: begin
                add(9, 1'($urandom), 1'($urandom), 6'($urandom));
                e_build.n_pcw++;
                e_build.pcsrc = 2'd2;
            end
            OP_ADDI: begin
                add(10, 1'($urandom), 1'($urandom), 6'($urandom));
                add(11, 1'($urandom), 1'($urandom), 6'($urandom));
                e_build.n_rw = 1;
            end
            default: e_build.n_ill = 1;
        endcase

        exp_q.push_back(e_build);
        foreach (cyc_q[i]) begin
            mem_ready = cyc_q[i].mr;
            zero      = cyc_q[i].z;
            opcode    = cyc_q[i].op;
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor ----------------
    int          a_lat, a_rw, a_mwacc, a_pcw, a_irw, a_ill, a_iord, a_mr;
    logic [63:0] a_sig;
    logic        a_mtr, a_rd;
    logic [3:0]  a_alu;
    logic [1:0]  a_pcsrc;

    task automatic clear_acc();
        a_lat = 0; a_rw = 0; a_mwacc = 0; a_pcw = 0; a_irw = 0; a_ill = 0;
        a_iord = 0; a_mr = 0; a_sig = '0; a_mtr = 1'b0; a_rd = 1'b0;
        a_alu = 4'b0000; a_pcsrc = 2'd3;
    endtask

    initial begin
        exp_t e;
        clear_acc();
        forever begin
            @(negedge clk);
            if (rst) begin
                clear_acc();
            end else begin
                a_lat++;
                a_sig = (a_sig << 4) | 64'(state);
                if (RegWrite) begin
                    a_rw++;
                    a_mtr = MemtoReg;
                    a_rd  = RegDst;
                end
                if (MemWrite && mem_ready) a_mwacc++;
                if (PCWrite) begin
                    a_pcw++;
                    if (!IRWrite) a_pcsrc = PCSource;
                end
                if (IRWrite)    a_irw++;
                if (illegal_op) a_ill++;
                if (IorD)       a_iord++;
                if (MemRead)    a_mr++;
                a_alu = a_alu | (4'b0001 << ALUOpcode);
                if (instr_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_instr_done", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("latency",      64'(a_lat),    64'(e.lat));
                        check("state_path",   a_sig,         e.sig);
                        check("regwrite_cnt", 64'(a_rw),     64'(e.n_rw));
                        check("memwrite_cnt", 64'(a_mwacc),  64'(e.n_mwacc));
                        check("pcwrite_cnt",  64'(a_pcw),    64'(e.n_pcw));
                        check("irwrite_cnt",  64'(a_irw),    64'(e.n_irw));
                        check("illegal_cnt",  64'(a_ill),    64'(e.n_ill));
                        check("iord_cnt",     64'(a_iord),   64'(e.n_iord));
                        check("memread_cnt",  64'(a_mr),     64'(e.n_mr));
                        check("wb_memtoreg",  64'(a_mtr),    64'(e.wb_mtr));
                        check("wb_regdst",    64'(a_rd),     64'(e.wb_rd));
                        check("aluop_set",    64'(a_alu),    64'(e.alu_mask));
                        check("pcsource",     64'(a_pcsrc),  64'(e.pcsrc));
                    end
                    clear_acc();
                end else if (a_lat > 40) begin
                    check("instr_done_watchdog", 64'(a_lat), 64'(0));
                    clear_acc();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] rop;
        rst       = 1'b1;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b1;   // high during reset: IRWrite/PCWrite must stay masked
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'(state), 64'(0));
        check("reset_outs",  64'(w_all_outs), 64'(0));

        // Directed: start a lw, abandon it with an async reset in MEM_READ.
        rst = 1'b0;
        @(negedge clk);
        check("fetch_state",   64'(state),   64'(0));
        check("fetch_memread", 64'(MemRead), 64'(1));
        @(posedge clk); #1;
        opcode = OP_LW; mem_ready = 1'b0;
        @(posedge clk); #1;
        opcode = 6'($urandom);
        @(posedge clk); #1;
        @(negedge clk);
        check("midlw_state", 64'(state), 64'(3));
        check("midlw_iord",  64'(IorD),  64'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 64'(state),      64'(0));
        check("async_rst_outs",  64'(w_all_outs), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        fork
            issue(OP_R, 1'b0, 0, 0);
            begin
                @(negedge clk);
                check("post_rst_state",   64'(state),   64'(0));
                check("post_rst_memread", 64'(MemRead), 64'(1));
            end
        join

        // Directed corner cases from the test plan.
        issue(OP_LW,   1'b0, 0, 3);
        issue(OP_BEQ,  1'b1, 0, 0);
        issue(OP_BNE,  1'b1, 0, 0);
        issue(OP_J,    1'b0, 0, 0);
        issue(OP_ADDI, 1'b0, 0, 0);
        issue(6'h3f,   1'b0, 0, 0);
        issue(OP_SW,   1'b0, 2, 2);

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0: rop = OP_R;
                1: rop = OP_LW;
                2: rop = OP_SW;
                3: rop = OP_BEQ;
                4: rop = OP_BNE;
                5: rop = OP_ADDI;
                6: rop = OP_J;
                default: begin
                    rop = 6'($urandom);
                    while (is_legal(rop)) rop = 6'($urandom);
                end
            endcase
            issue(rop, 1'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
        end

        mem_ready = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
